// File: rtl/fractal_render.sv
// rtl/fractal_render.sv - Mandelbrot escape-time renderer writing one count per pixel into a frame buffer.
// Optional FRACTAL_AUTO_RESTART_EN: chain frames back-to-back from DONE, re-latching the view inputs.
module fractal_render #(
    parameter int W      = 16,
    parameter int FRAC   = 12,
    parameter int HRES   = 640,
    parameter int VRES   = 480,
    parameter int ITER_W = 7,
    parameter int ADDR_W = 19
) (
    input  logic              Clk_100M,
    input  logic              reset,
    input  logic              start,
    input  logic [W-1:0]      start_x,
    input  logic [W-1:0]      start_y,
    input  logic [W-1:0]      step_x,
    input  logic [W-1:0]      step_y,
    input  logic [ITER_W-1:0] max_iter,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_w,
    output logic [ITER_W-1:0] din,
    output logic              wea
);

    localparam int COL_W  = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int LINE_W = $clog2(VRES + 1);
    localparam logic signed [2*W:0] ESC_LIM =
        {{(2*W-2-2*FRAC){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_WRITE, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic signed [W-1:0]  r_sx, r_stx, r_sty;
    logic signed [W-1:0]  r_cx, r_cy;
    logic signed [W-1:0]  r_zx, r_zy;
    logic [ITER_W-1:0]    r_max;
    logic [ITER_W-1:0]    r_iter;
    logic [COL_W-1:0]     r_col;
    logic [LINE_W-1:0]    r_line;
    logic [ADDR_W-1:0]    r_addr;
    logic [ITER_W-1:0]    r_din;

    logic signed [2*W-1:0] w_zx_ext, w_zy_ext;
    logic signed [2*W-1:0] w_xx, w_yy, w_xy;
    logic signed [2*W:0]   w_mag, w_diff, w_xy2, w_diff_sh, w_xy2_sh;
    logic                  w_escape, w_limit, w_last_col, w_last_pix, w_new_frame;

    // Operands are sign-extended to 2W so the low 2W product bits are the exact signed product.
    assign w_zx_ext  = {{W{r_zx[W-1]}}, r_zx};
    assign w_zy_ext  = {{W{r_zy[W-1]}}, r_zy};
    assign w_xx      = w_zx_ext * w_zx_ext;
    assign w_yy      = w_zy_ext * w_zy_ext;
    assign w_xy      = w_zx_ext * w_zy_ext;
    assign w_mag     = {w_xx[2*W-1], w_xx} + {w_yy[2*W-1], w_yy};
    assign w_diff    = {w_xx[2*W-1], w_xx} - {w_yy[2*W-1], w_yy};
    assign w_xy2     = {w_xy, 1'b0};
    assign w_diff_sh = w_diff >>> FRAC;
    assign w_xy2_sh  = w_xy2 >>> FRAC;

    assign w_escape   = (w_mag > ESC_LIM);
    assign w_limit    = (r_iter == r_max);
    assign w_last_col = (r_col == COL_W'(HRES - 1));
    assign w_last_pix = w_last_col && (r_line == LINE_W'(VRES - 1));

`ifdef FRACTAL_AUTO_RESTART_EN
    assign w_new_frame = ((r_state == S_IDLE) && start) || (r_state == S_DONE);
`else
    assign w_new_frame = (r_state == S_IDLE) && start;
`endif

    always_ff @(posedge Clk_100M or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_ITER;
            S_ITER:  if (w_escape || w_limit) w_next = S_WRITE;
            S_WRITE: w_next = w_last_pix ? S_DONE : S_LOAD;
`ifdef FRACTAL_AUTO_RESTART_EN
            S_DONE:  w_next = S_LOAD;
`else
            S_DONE:  w_next = S_IDLE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        wea  = (r_state == S_WRITE);
        done = (r_state == S_DONE);
`ifdef FRACTAL_AUTO_RESTART_EN
        busy = (r_state != S_IDLE);
`else
        busy = (r_state == S_LOAD) || (r_state == S_ITER) || (r_state == S_WRITE);
`endif
    end

    always_ff @(posedge Clk_100M or posedge reset) begin
        if (reset) begin
            r_sx   <= '0;
            r_stx  <= '0;
            r_sty  <= '0;
            r_max  <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_zx   <= '0;
            r_zy   <= '0;
            r_iter <= '0;
            r_col  <= '0;
            r_line <= '0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            // View parameters are captured once per frame; later input changes are invisible.
            if (w_new_frame) begin
                r_sx   <= start_x;
                r_stx  <= step_x;
                r_sty  <= step_y;
                r_max  <= max_iter;
                r_cx   <= start_x;
                r_cy   <= start_y;
                r_col  <= '0;
                r_line <= '0;
                r_addr <= '0;
            end
            case (r_state)
                S_LOAD: begin
                    r_zx   <= '0;
                    r_zy   <= '0;
                    r_iter <= '0;
                end
                S_ITER: begin
                    if (w_escape || w_limit) begin
                        r_din <= r_iter;
                    end else begin
                        r_zx   <= w_diff_sh[W-1:0] + r_cx;
                        r_zy   <= w_xy2_sh[W-1:0] + r_cy;
                        r_iter <= r_iter + ITER_W'(1);
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_last_col) begin
                        r_col  <= '0;
                        r_cx   <= r_sx;
                        r_line <= r_line + LINE_W'(1);
                        r_cy   <= r_cy + r_sty;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                        r_cx  <= r_cx + r_stx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr_w = r_addr;
    assign din    = r_din;

endmodule

// File: doc/fractal_render.md
Name: fractal_render

Overview:
- Parametrised Mandelbrot render engine. Successor to the current fixed-view fractal path.
- View window (start/step) and iteration limit are runtime inputs, latched per frame, instead of hard-wired constants.
- Scans an HRES x VRES grid in raster order and computes one escape-time count per pixel.
- Writes each count into the pixel_gen frame buffer through the addr_w/dina/wea write port.
- A start/busy/done handshake lets a controller trigger renders for zoom and pan.

Parameters:
- W, 16, fixed-point word width of coordinates, two's complement.
- FRAC, 12, fractional bits; W-FRAC must be >= 4, giving a range of ±8.0.
- HRES, 640, pixels per line.
- VRES, 480, lines per frame.
- ITER_W, 7, width of the iteration count and of din.
- ADDR_W, 19, frame-buffer address width; 2^ADDR_W must be >= HRES*VRES.

Ports:
- Clk_100M  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to render a frame; honoured only in IDLE.
- start_x  in  W  real part of c for pixel (0,0).
- start_y  in  W  imaginary part of c for pixel (0,0).
- step_x  in  W  increment of the real part per pixel column.
- step_y  in  W  increment of the imaginary part per line.
- max_iter  in  ITER_W  iteration limit for this frame.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse after the last pixel's write.
- addr_w  out  ADDR_W  frame-buffer write address = line*HRES + column.
- din  out  ITER_W  escape count for the pixel at addr_w.
- wea  out  1  write strobe, one cycle per pixel.

Behaviour:
- Reset (asynchronous, any state) forces:
  - state = IDLE; busy = 0; done = 0; wea = 0; addr_w = 0; din = 0.
  - column, line and iteration counters = 0; z = 0.
  - Any partial frame is abandoned; no further writes occur.
- FSM states: IDLE, LOAD, ITER, WRITE, DONE.
- IDLE:
  - On start = 1, latch start_x, start_y, step_x, step_y and max_iter.
  - Set cx = start_x, cy = start_y, column = line = 0, addr_w = 0, then go to LOAD.
  - Input changes after acceptance do not affect the frame in progress.
- LOAD (1 cycle): zx = zy = 0, iter = 0, go to ITER.
- ITER (1 cycle per step):
  - Form full 2W-bit products xx = zx*zx, yy = zy*zy, xy = zx*zy, each with 2*FRAC fractional bits.
  - Escape when xx + yy, computed at 2W+1 bits, is strictly greater than 4 << (2*FRAC).
  - If escape or iter == max_iter: din <= iter, go to WRITE.
  - Otherwise:
    - zx <= (xx - yy) >>> FRAC + cx, truncated to W.
    - zy <= (2*xy) >>> FRAC + cy, truncated to W.
    - iter <= iter + 1.
- WRITE (1 cycle):
  - wea = 1 with the current addr_w and din.
  - Then advance: column++, cx += step_x, addr_w++.
  - When column == HRES-1: column = 0, cx = start_x, line++, cy += step_y.
  - When line == VRES-1 and column == HRES-1: go to DONE; otherwise go to LOAD.
- DONE (1 cycle): done = 1, busy = 0, go to IDLE.
- Per-pixel cycle count is 1 (LOAD) + (iter+1) (ITER) + 1 (WRITE).
- max_iter = 0: every pixel gets din = 0 after a single ITER cycle.
- start while busy, or during the DONE cycle, is ignored; it is not queued.
- addr_w is an incrementing counter; no multiplier is used for addressing.
- cx and cy accumulate with wrap-around at W bits; range checking is the caller's responsibility.
- Boundary: |z|² exactly 4.0 does not escape.

Optional Feature:
- Macro: FRACTAL_AUTO_RESTART_EN.
- Defined: from DONE the block returns directly to LOAD for a new frame, re-latching all inputs at that cycle.
  - busy stays 1 continuously.
  - done still pulses for one cycle per frame.
  - start is ignored except in the first IDLE after reset.
- Undefined: the block returns to IDLE after DONE and waits for start.

Test Plan (bench uses HRES=4, VRES=3, ADDR_W=4):
- Reset asserted mid-ITER of pixel 5 -> busy, done, wea and addr_w read 0 asynchronously; no wea until the next start.
- start_x = start_y = 0, steps = 0, max_iter = 100:
  - 12 wea pulses at addr 0..11, all with din = 100.
  - Then exactly one done pulse.
- start_x = 0x1000 (+1.0), start_y = 0, steps = 0, max_iter = 100 -> every din = 3; wea pulses exactly 6 cycles apart.
- start_x = 0xE000 (-2.0), start_y = 0, steps = 0, max_iter = 50 -> |z|² = 4.0 never escapes; every din = 50.
- start pulsed on the second cycle after acceptance and again during DONE -> only one frame rendered; busy low for at least 1 cycle before the next accepted start.
- start_x = 0, step_x = 0x0400, step_y = 0x0400, and start_x changed mid-frame -> per-line cx sequence 0, 0.25, 0.5, 0.75 resets each line; the mid-frame change has no effect.
